// File: rtl/seg_code_decoder.sv
// seg_code_decoder: receive side of the ALU seven-segment display code.
// Captures an 8-bit segment pattern (bit 7 = minus/dot, bits 6:0 = segments g..a).
// The pattern must hold for STABLE_CYCLES cycles before it is accepted. An accepted
// pattern is decoded to a signed 4-bit value and added to a saturating accumulator.
// Error and unknown codes are counted.
//
// Optional build macro: SEG_ACTIVE_LOW_EN inverts seg_in before capture and compare,
// for common-anode sources. Ports and timing are the same in both builds.
//
// Ports:
//   clk_2       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   seg_in      in   [7:0] segment code under test
//   seg_strobe  in   sample request, honoured only when idle
//   clear       in   synchronous clear of acc/acc_ovf/err_count, aborts in-flight code
//   value       out  [3:0] last decoded signed value (held)
//   value_valid out  pulse: value updated from a legal numeric code
//   code_err    out  pulse: accepted code was 0x80
//   bad_code    out  pulse: accepted code not in decode table
//   acc         out  [ACC_W-1:0] saturating signed running sum
//   acc_ovf     out  sticky saturation flag
//   err_count   out  [CNT_W-1:0] saturating error event count
//   busy        out  FSM not idle
module seg_code_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ACC_W         = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [7:0]       seg_in,
  input  logic             seg_strobe,
  input  logic             clear,
  output logic [3:0]       value,
  output logic             value_valid,
  output logic             code_err,
  output logic             bad_code,
  output logic [ACC_W-1:0] acc,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned CntW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  // Count value from which one more matching cycle completes the stability window.
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StConfirm, StDecode} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cap_q, cap_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       value_q;
  logic             valid_q, code_err_q, bad_code_q, ovf_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] err_q;

  logic [7:0]       seg_eff;
  logic [3:0]       dec_val;
  logic             dec_num, dec_err;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] acc_sat;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_eff = ~seg_in;
`else
  assign seg_eff = seg_in;
`endif

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seg_strobe) begin
            cap_d   = seg_eff;
            cnt_d   = CntOne;
            state_d = (STABLE_CYCLES <= 1) ? StDecode : StConfirm;
          end
        end
        StConfirm: begin
          if (seg_eff == cap_q) begin
            cnt_d = cnt_q + CntOne;
            if (cnt_q == StableLast) state_d = StDecode;
          end else begin
            // Input moved: restart the stability window on the new code.
            cap_d = seg_eff;
            cnt_d = CntOne;
          end
        end
        StDecode: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    dec_val = 4'h0;
    dec_num = 1'b1;
    dec_err = 1'b0;
    case (cap_q)
      8'h3F: dec_val = 4'h0;
      8'h06: dec_val = 4'h1;
      8'h5B: dec_val = 4'h2;
      8'h4F: dec_val = 4'h3;
      8'h86: dec_val = 4'hF;
      8'hDB: dec_val = 4'hE;
      8'hCF: dec_val = 4'hD;
      8'hE6: dec_val = 4'hC;
      8'h80: begin
        dec_num = 1'b0;
        dec_err = 1'b1;
      end
      default: dec_num = 1'b0;
    endcase
  end

  // One guard bit: overflow shows as disagreement between the top two sum bits.
  always_comb begin
    sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 3){dec_val[3]}}, dec_val};
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    acc_sat = sum_ovf ? (sum[ACC_W] ? AccMin : AccMax) : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cap_q      <= '0;
      cnt_q      <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      bad_code_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      bad_code_q <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        err_q <= '0;
      end else if (state_q == StDecode) begin
        if (dec_num) begin
          value_q <= dec_val;
          valid_q <= 1'b1;
          acc_q   <= acc_sat;
          if (sum_ovf) ovf_q <= 1'b1;
        end else begin
          code_err_q <= dec_err;
          bad_code_q <= ~dec_err;
          if (err_q != {CNT_W{1'b1}}) err_q <= err_q + CNT_W'(1);
        end
      end
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign code_err    = code_err_q;
  assign bad_code    = bad_code_q;
  assign acc         = acc_q;
  assign acc_ovf     = ovf_q;
  assign err_count   = err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_seg_code_decoder.sv
// Directed self-checking bench for seg_code_decoder (STABLE_CYCLES=4, ACC_W=8, CNT_W=4).
module tb_seg_code_decoder;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seg_in = 8'h00;
  logic       seg_strobe = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] value;
  logic       value_valid, code_err, bad_code, acc_ovf, busy;
  logic [7:0] acc;
  logic [3:0] err_count;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned npulse;

  seg_code_decoder #(
    .STABLE_CYCLES(4),
    .ACC_W        (8),
    .CNT_W        (4)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .seg_in     (seg_in),
    .seg_strobe (seg_strobe),
    .clear      (clear),
    .value      (value),
    .value_valid(value_valid),
    .code_err   (code_err),
    .bad_code   (bad_code),
    .acc        (acc),
    .acc_ovf    (acc_ovf),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk_2 = ~clk_2;

  // Source polarity for this build.
  function automatic logic [7:0] enc(input logic [7:0] c);
`ifdef SEG_ACTIVE_LOW_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Strobe one code and advance to the cycle where its result pulse is visible.
  task automatic accept(input logic [7:0] c);
    seg_in     = c;
    seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_value", value, 0);
    chk("rst_valid", value_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", acc_ovf, 0);
    chk("rst_err", err_count, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Basic acceptance of 3, latency 4 edges
    seg_in     = enc(8'h4F);
    seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    chk("t1_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("t1_early", value_valid, 0);
    chk("t1_busy_dec", busy, 1);
    tick();
    chk("t1_valid", value_valid, 1);
    chk("t1_value", value, 3);
    chk("t1_acc", acc, 3);
    chk("t1_busy_end", busy, 0);
    tick();
    chk("t1_pulse_end", value_valid, 0);

    // Code changes mid-window: restart on new code
    seg_in     = enc(8'h4F);
    seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    tick();
    seg_in = enc(8'h06);
    npulse = 0;
    repeat (4) begin
      tick();
      if (value_valid) npulse++;
    end
    chk("t2_no_early", npulse, 0);
    tick();
    chk("t2_valid", value_valid, 1);
    chk("t2_value", value, 1);
    chk("t2_acc", acc, 4);

    // Saturation at -128
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clr_acc", acc, 0);
    repeat (32) accept(enc(8'hE6));
    chk("t3_acc32", acc, 32'h80);
    chk("t3_ovf32", acc_ovf, 0);
    accept(enc(8'hE6));
    chk("t3_acc33", acc, 32'h80);
    chk("t3_ovf33", acc_ovf, 1);
    chk("t3_value", value, 4'hC);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clr_acc2", acc, 0);
    chk("t3_clr_ovf", acc_ovf, 0);
    chk("t3_keep_val", value, 4'hC);

    // Error codes
    accept(enc(8'h80));
    chk("t4_code_err", code_err, 1);
    chk("t4_not_bad", bad_code, 0);
    chk("t4_no_valid", value_valid, 0);
    chk("t4_err1", err_count, 1);
    accept(enc(8'h12));
    chk("t4_bad", bad_code, 1);
    chk("t4_no_cerr", code_err, 0);
    chk("t4_err2", err_count, 2);
    chk("t4_value", value, 4'hC);
    chk("t4_acc", acc, 0);
    for (int i = 0; i < 15; i++) accept(enc((i % 2 == 0) ? 8'h80 : 8'h12));
    chk("t4_err_sat", err_count, 15);

    // Strobe held: one acceptance per 5 cycles
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_err_clr", err_count, 0);
    seg_in     = enc(8'h5B);
    seg_strobe = 1'b1;
    npulse     = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (value_valid) npulse++;
    end
    seg_strobe = 1'b0;
    chk("t5_pulses", npulse, 4);
    repeat (6) begin
      tick();
      if (value_valid) npulse++;
    end
    chk("t5_no_extra", npulse, 4);
    chk("t5_acc", acc, 8);
    chk("t5_value", value, 2);

    // clear wins over DECODE
    seg_in     = enc(8'h06);
    seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    repeat (3) tick();
    chk("t6_in_decode", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_no_pulse", value_valid, 0);
    chk("t6_acc", acc, 0);
    chk("t6_busy", busy, 0);
    chk("t6_value", value, 2);

    // Asynchronous reset during CONFIRM
    accept(enc(8'h4F));
    accept(enc(8'h80));
    seg_in     = enc(8'h06);
    seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_value", value, 0);
    chk("t7_acc", acc, 0);
    chk("t7_err", err_count, 0);
    npulse = 0;
    repeat (5) begin
      tick();
      if (value_valid) npulse++;
    end
    chk("t7_no_pulse", npulse, 0);
    reset = 1'b0;
    tick();

    // Polarity check on the raw bus
    accept(enc(8'h06));
    chk("t8_value1", value, 1);
`ifdef SEG_ACTIVE_LOW_EN
    accept(8'hC0);
    chk("t8_valid", value_valid, 1);
    chk("t8_value0", value, 0);
`else
    accept(8'hC0);
    chk("t8_bad", bad_code, 1);
    chk("t8_value_kept", value, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
